distribute_node_fifo: RTL

Per-node receive buffer that sits directly downstream of the node-side output of a 1x2 one-hot distribute switch, i.e. on the switch's upper output lane and upper valid bit. The distribute chain has no backpressure, so this block absorbs bursts of node-bound words into a small FIFO and presents them to the PE through a valid/ready handshake. Words that arrive while the buffer is full are dropped and flagged.

---
 rtl/distribute_node_fifo.sv | 89 ++++++++
 1 files changed

// File: rtl/distribute_node_fifo.sv
// Per-node receive buffer behind the node lane of a distribute switch.
// Latency: 1 cycle write-to-read; first-word-fall-through head word.
// Backpressure: none upstream; words arriving while full are dropped and flagged.
module distribute_node_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_full,
    output logic                  o_overflow,
    input  logic                  i_clr_overflow
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  drop;

    // Handshake decode; a pop frees a slot so a push into a full buffer still lands.
    always_comb begin
        push   = i_valid;
        pop    = i_ready && o_valid;
        accept = push && (!o_full || pop);
        drop   = push && o_full && !pop;
    end

    // Storage array carries no reset; only the control state does.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH; occupancy tracked separately.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !accept) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
        end
    end

    // Outputs come from registered state only; head word masked to zero when empty.
    always_comb begin
        o_valid = (cnt != '0);
        o_full  = (cnt == DEPTH_CNT);
        o_count = cnt;
        o_data  = o_valid ? mem[rd_ptr] : '0;
    end

endmodule
